// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, register constants and grant encoding for the WB port arbiter
package wb_port_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
  typedef enum logic [2:0] {G_NONE, G_FORCE, G_PIPE, G_HEAD, G_BYPASS} grant_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: WB stage, aux source and register-file write-port signals of the arbiter
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int size  = XLEN,
  parameter int DEPTH = 2
);
  logic                        pipe_valid_i;
  logic                        pipe_we_i;
  logic [REG_ADDR_W-1:0]       pipe_rd_i;
  logic [size-1:0]             pipe_data_i;
  logic                        pipe_stall_o;
  logic                        aux_valid_i;
  logic [REG_ADDR_W-1:0]       aux_rd_i;
  logic [size-1:0]             aux_data_i;
  logic                        aux_ready_o;
  logic                        rf_we_o;
  logic [REG_ADDR_W-1:0]       rf_rd_o;
  logic [size-1:0]             rf_data_o;
  logic                        aux_pending_o;
  logic [$clog2(DEPTH):0]      q_count_o;
  modport master (
    output pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_data_i, aux_valid_i, aux_rd_i, aux_data_i,
    input  pipe_stall_o, aux_ready_o, rf_we_o, rf_rd_o, rf_data_o, aux_pending_o, q_count_o
  );
  modport slave (
    input  pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_data_i, aux_valid_i, aux_rd_i, aux_data_i,
    output pipe_stall_o, aux_ready_o, rf_we_o, rf_rd_o, rf_data_o, aux_pending_o, q_count_o
  );
endinterface

// File: rtl/wb_aux_fifo.sv
// wb_aux_fifo: {rd,data,live} result FIFO with kill-by-rd; free slots are always kept dead
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = XLEN,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   kill,
  input  logic [REG_ADDR_W-1:0]  push_rd,
  input  logic [W-1:0]           push_data,
  input  logic [REG_ADDR_W-1:0]  kill_rd,
  output logic [REG_ADDR_W-1:0]  head_rd,
  output logic [W-1:0]           head_data,
  output logic                   head_live,
  output logic                   any_live,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [W-1:0]          data_q [DEPTH];
  logic [DEPTH-1:0]      live_q;
  logic [AW-1:0]         wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && rd_q[i] == kill_rd) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[rp] <= 1'b0;
        rp <= rp + AW'(1);
      end
      if (push) begin
        rd_q[wp] <= push_rd;
        data_q[wp] <= push_data;
        live_q[wp] <= 1'b1;
        wp <= wp + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head_rd   = rd_q[rp];
  assign head_data = data_q[rp];
  assign head_live = live_q[rp];
  assign any_live  = |live_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage and queued aux results
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int size     = XLEN,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic             clk,
  input logic             rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0]         wait_cnt;
  logic [AW:0]           count;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [size-1:0]       head_data;
  logic                  head_live, any_live, pipe_req, aux_req, ready, empty;
  logic                  head_grant, push, pop, kill;
  grant_e                grant;
  assign pipe_req = bus.pipe_valid_i & bus.pipe_we_i & (bus.pipe_rd_i != REG_X0);
  assign aux_req  = bus.aux_valid_i & (bus.aux_rd_i != REG_X0);
  assign empty    = count == '0;
  assign ready    = rst_n & (count < (AW+1)'(DEPTH));
  always_comb begin
    grant = !rst_n ? G_NONE :
            (head_live && pipe_req && wait_cnt == WW'(MAX_WAIT)) ? G_FORCE :
            pipe_req ? G_PIPE :
            head_live ? G_HEAD :
            (empty && aux_req && ready) ? G_BYPASS : G_NONE;
    head_grant = grant == G_FORCE || grant == G_HEAD;
    kill = grant == G_PIPE;
    pop  = rst_n & (head_grant | (!empty & !head_live));
    push = aux_req & ready & (grant != G_BYPASS) & !(kill && bus.aux_rd_i == bus.pipe_rd_i);
    bus.rf_we_o   = grant != G_NONE;
    bus.rf_rd_o   = head_grant ? head_rd : kill ? bus.pipe_rd_i :
                    grant == G_BYPASS ? bus.aux_rd_i : '0;
    bus.rf_data_o = head_grant ? head_data : kill ? bus.pipe_data_i :
                    grant == G_BYPASS ? bus.aux_data_i : '0;
    bus.pipe_stall_o  = grant == G_FORCE;
    bus.aux_ready_o   = ready;
    bus.aux_pending_o = any_live;
    bus.q_count_o     = count;
  end
  // a live head that loses ages toward a forced write; any other case restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (head_live && !head_grant) ?
                     (wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + WW'(1)) : '0;
  end
  wb_aux_fifo #(.W(size), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .kill      (kill),
    .push_rd   (bus.aux_rd_i),
    .push_data (bus.aux_data_i),
    .kill_rd   (bus.pipe_rd_i),
    .head_rd   (head_rd),
    .head_data (head_data),
    .head_live (head_live),
    .any_live  (any_live),
    .count     (count)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a write scoreboard checked by an rf-port monitor
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.size(32), .DEPTH(2)) bus ();
  wb_port_arbiter #(.size(32), .DEPTH(2), .MAX_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic drv(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                     input bit av, input logic [4:0] ard, input logic [31:0] ad);
    bus.pipe_valid_i = pv;
    bus.pipe_we_i = pv;
    bus.pipe_rd_i = prd;
    bus.pipe_data_i = pd;
    bus.aux_valid_i = av;
    bus.aux_rd_i = ard;
    bus.aux_data_i = ad;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
  endtask
  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    q.push_back('{cyc, rd, d});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.rf_we_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd=%0d data=%0h cycle %0d, no write expected",
                 bus.rf_rd_o, bus.rf_data_o, cyc);
      end else begin
        e_m = q.pop_front();
        chk("wr_cycle", cyc, e_m.c);
        chk("wr_rd", {27'd0, bus.rf_rd_o}, {27'd0, e_m.rd});
        chk("wr_data", bus.rf_data_o, e_m.d);
      end
    end
  end
  initial begin
    drv(1, 3, 32'h33, 1, 5, 32'h55);
    @(negedge clk);
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_ready", bus.aux_ready_o, 0);
    chk("rst_count", bus.q_count_o, 0);
    chk("rst_stall", bus.pipe_stall_o, 0);
    chk("rst_pending", bus.aux_pending_o, 0);
    step();
    step();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.aux_ready_o, 1);
    step();
    drv(0, 0, 0, 1, 5, 32'hA5);
    expw(5, 32'hA5);
    @(negedge clk);
    chk("byp_count", bus.q_count_o, 0);
    step();
    idle();
    @(negedge clk);
    chk("byp_count_after", bus.q_count_o, 0);
    step();
    drv(1, 1, 32'h101, 1, 7, 32'h77);
    expw(1, 32'h101);
    @(negedge clk);
    step();
    drv(1, 2, 32'h102, 0, 0, 0);
    expw(2, 32'h102);
    @(negedge clk);
    chk("q_count1", bus.q_count_o, 1);
    chk("q_pending1", bus.aux_pending_o, 1);
    step();
    drv(1, 3, 32'h103, 0, 0, 0);
    expw(3, 32'h103);
    @(negedge clk);
    step();
    idle();
    expw(7, 32'h77);
    @(negedge clk);
    chk("q_drain_count", bus.q_count_o, 1);
    step();
    @(negedge clk);
    chk("q_empty", bus.q_count_o, 0);
    chk("q_pending0", bus.aux_pending_o, 0);
    step();
    drv(1, 10, 32'h10A, 1, 9, 32'h99);
    expw(10, 32'h10A);
    @(negedge clk);
    step();
    for (int k = 1; k <= 4; k++) begin
      drv(1, 5'(10 + k), 32'h10A + k, 0, 0, 0);
      expw(5'(10 + k), 32'h10A + k);
      @(negedge clk);
      chk("starve_nostall", bus.pipe_stall_o, 0);
      step();
    end
    drv(1, 15, 32'h115, 0, 0, 0);
    expw(9, 32'h99);
    @(negedge clk);
    chk("starve_stall", bus.pipe_stall_o, 1);
    step();
    expw(15, 32'h115);
    @(negedge clk);
    chk("held_nostall", bus.pipe_stall_o, 0);
    chk("starve_count", bus.q_count_o, 0);
    step();
    drv(1, 8, 32'h108, 1, 4, 32'h11);
    expw(8, 32'h108);
    @(negedge clk);
    step();
    drv(1, 4, 32'h22, 0, 0, 0);
    expw(4, 32'h22);
    @(negedge clk);
    chk("waw_live", bus.aux_pending_o, 1);
    step();
    idle();
    @(negedge clk);
    chk("waw_dead_count", bus.q_count_o, 1);
    chk("waw_dead_pending", bus.aux_pending_o, 0);
    step();
    @(negedge clk);
    chk("waw_popped", bus.q_count_o, 0);
    step();
    drv(1, 6, 32'h66, 1, 6, 32'h67);
    expw(6, 32'h66);
    @(negedge clk);
    chk("waw_same_ready", bus.aux_ready_o, 1);
    step();
    idle();
    @(negedge clk);
    chk("waw_same_count", bus.q_count_o, 0);
    step();
    drv(1, 1, 32'h201, 1, 20, 32'h200);
    expw(1, 32'h201);
    @(negedge clk);
    step();
    drv(1, 2, 32'h202, 1, 21, 32'h210);
    expw(2, 32'h202);
    @(negedge clk);
    chk("full_count1", bus.q_count_o, 1);
    step();
    drv(1, 3, 32'h203, 1, 22, 32'h220);
    expw(3, 32'h203);
    @(negedge clk);
    chk("full_count2", bus.q_count_o, 2);
    chk("full_ready", bus.aux_ready_o, 0);
    step();
    drv(0, 0, 0, 1, 22, 32'h220);
    expw(20, 32'h200);
    @(negedge clk);
    chk("full_nocredit", bus.aux_ready_o, 0);
    step();
    expw(21, 32'h210);
    @(negedge clk);
    chk("full_ready_again", bus.aux_ready_o, 1);
    chk("full_count_pp", bus.q_count_o, 1);
    step();
    idle();
    expw(22, 32'h220);
    @(negedge clk);
    chk("full_last", bus.q_count_o, 1);
    step();
    drv(1, 0, 32'hBAD, 1, 0, 32'hDEAD);
    @(negedge clk);
    chk("x0_ready", bus.aux_ready_o, 1);
    chk("x0_count", bus.q_count_o, 0);
    step();
    idle();
    bus.pipe_valid_i = 1'b1;
    bus.pipe_rd_i = 12;
    @(negedge clk);
    chk("x0_after", bus.q_count_o, 0);
    step();
    drv(1, 1, 32'h301, 1, 23, 32'h230);
    expw(1, 32'h301);
    @(negedge clk);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_count", bus.q_count_o, 0);
    chk("midrst_pending", bus.aux_pending_o, 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_after", bus.q_count_o, 0);
    repeat (3) step();
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
